dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder that services the load/store requests issued by the pipelined datapath's Memory stage. It accepts one word request at a time, models a configurable multi-cycle array access, returns read data with a one-cycle acknowledge, and drives a stall to the hazard unit while an access is outstanding. It sits between the datapath's `aluoutM`/`writedataM`/`readdataM` path and a word-organised on-chip RAM.

## Interface

Parameters:
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: array access cycles; 1 ≤ LATENCY ≤ 15.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req`, input, 1: request valid; held by the requester until `ack`.
- `we`, input, 1: 1 means store, 0 means load; sampled with `req`.
- `addr`, input, 32: byte address (`aluoutM`).
- `wdata`, input, 32: store data (`writedataM`).
- `rdata`, output, 32: load data (`readdataM`); registered.
- `ack`, output, 1: one-cycle completion pulse.
- `err`, output, 1: valid only with `ack`; the request was rejected.
- `stall`, output, 1: the requester must hold its Memory stage this cycle.

## Operation

- FSM states: IDLE, BUSY, DONE, ERR.
- **IDLE**
  - When `req`=1, latch `we`, `addr`, and `wdata`.
  - Perform the address check on the incoming `addr`:
    - Misaligned: `addr[1:0]` ≠ 00.
    - Out of range: `addr[31:2]` ≥ DEPTH.
  - If the check fails, go to ERR.
  - If the check passes, go to BUSY and load the down-counter with LATENCY-1.
- **BUSY**
  - While the counter is nonzero, decrement it on each edge.
  - On the edge where the counter is 0, perform the access and go to DONE:
    - Store: `mem[addr[log2(DEPTH)+1:2]] <= wdata`.
    - Load: `rdata <= mem[index]`.
- **DONE**
  - `ack`=1 and `err`=0.
  - Unconditionally return to IDLE. `req` is ignored this cycle.
  - A still-asserted `req` is treated as a new request in the following IDLE cycle.
- **ERR**
  - `ack`=1 and `err`=1.
  - No array write occurs and `rdata` is unchanged.
  - Return to IDLE.
- `stall` (combinational) = (state==IDLE & `req`) | (state==BUSY). It is 0 in DONE and ERR, so the pipeline advances on the `ack` cycle.
- `rdata` holds its last load value across stores, errors, and idle cycles. Stores never modify `rdata`.
- The array is not reset; its contents are undefined until written.
- Index width is log2(DEPTH). Upper address bits are used only for the range check.

## Timing

- Reset values while `reset`=0: state=IDLE, counter=0, `rdata`=0, `ack`=0, `err`=0, `stall`=0.
- Reset is asynchronous: asserting `reset` mid-access aborts it. A store still in BUSY is not written, and `ack` is not generated.
- Valid request latency, with `req` first high in cycle 0:
  - BUSY occupies cycles 1..LATENCY.
  - `ack` is high in cycle LATENCY+1.
  - `stall` is high in cycles 0..LATENCY.
  - For LATENCY=2: `stall` high in cycles 0–2, `ack` in cycle 3.
- Error latency: `stall` high in cycle 0 only, `ack`=`err`=1 in cycle 1.
- Load data is valid in the `ack` cycle and persists afterwards.
- Back-to-back requests: the minimum spacing is LATENCY+2 cycles between accepted requests, because of the mandatory pass through IDLE after DONE.
- Changes on `we`, `addr`, or `wdata` while in BUSY have no effect; the latched values are used.
- `ack` is never asserted for two consecutive cycles.

## Test plan

- **Store then load, LATENCY=2.**
  - Store `addr`=0x0000_0010, `wdata`=0xDEAD_BEEF, then load from 0x10.
  - Required: `ack` in cycle 3 of each request; `rdata`=0xDEAD_BEEF in the load's `ack` cycle; `stall` pattern 1,1,1,0 for each request.
- **Misaligned and out-of-range errors.**
  - Load `addr`=0x0000_0012 → `ack`=`err`=1 in cycle 1.
  - Store `addr`=0x0000_0400 with DEPTH=256 → `err`=1 and no array write.
  - A following load from 0x0 returns the prior contents of word 0 unchanged.
- **Reset mid-store.**
  - Store 0x1234_5678 to 0x20; drop `reset` in cycle 1 for one cycle, and leave `req` deasserted for the rest of the sequence so the aborted store is not re-accepted.
  - Required: `ack` never asserted; `rdata`=0.
  - Preload word 0x20 with 0xAAAA_AAAA; a later load of 0x20 returns 0xAAAA_AAAA.
- **LATENCY=1 and LATENCY=15 builds.**
  - The `ack` cycle is 2 and 16 respectively.
  - `stall` is high for exactly LATENCY+1 cycles.
- **Held request across `ack`.**
  - Keep `req`=1 through the `ack` cycle with the same load to 0x8.
  - Required: a second independent `ack` arrives LATENCY+2 cycles after the first, and there is no double `ack`.
- **Input change while BUSY.**
  - During BUSY of a store to 0x4, change `addr` to 0x8 and `wdata` to 0.
  - Required: word 0x4 receives the originally latched data and word 0x8 is untouched.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the Memory stage and the data-memory responder.
`timescale 1ns/1ps
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err, stall
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one word request at a time, multi-cycle array access,
// one-cycle ack (with err on rejected requests), stall while an access is pending.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StErr} state_e;

  state_e            stateQ, stateD;
  logic [3:0]        cntQ, cntD;
  logic              weQ;
  logic [IdxW-1:0]   idxQ;
  logic [31:0]       wdataQ;
  logic [31:0]       rdataQ;
  logic [31:0]       mem [DEPTH];

  logic addrOk;
  logic accept;
  logic access;

  // Upper address bits only matter for the range check.
  assign addrOk = (bus.addr[1:0] == 2'b00) && ({2'b00, bus.addr[31:2]} < DEPTH);
  assign accept = (stateQ == StIdle) && bus.req;
  assign access = (stateQ == StBusy) && (cntQ == 4'd0);

  // State and latency counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
      cntQ   <= 4'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Next-state logic; DONE/ERR always pass through IDLE before a new request.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.req) begin
          if (addrOk) begin
            stateD = StBusy;
            cntD   = 4'(LATENCY - 1);
          end else begin
            stateD = StErr;
          end
        end
      end
      StBusy: begin
        if (cntQ == 4'd0) stateD = StDone;
        else              cntD   = cntQ - 4'd1;
      end
      StDone:  stateD = StIdle;
      StErr:   stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // Output decode; stall covers the accept cycle and the whole BUSY window.
  always_comb begin
    bus.ack   = 1'b0;
    bus.err   = 1'b0;
    bus.stall = 1'b0;
    unique case (stateQ)
      StIdle: bus.stall = bus.req;
      StBusy: bus.stall = 1'b1;
      StDone: bus.ack   = 1'b1;
      StErr: begin
        bus.ack = 1'b1;
        bus.err = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rdata = rdataQ;

  // Latch the request on acceptance so later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weQ    <= 1'b0;
      idxQ   <= '0;
      wdataQ <= 32'd0;
    end else if (accept) begin
      weQ    <= bus.we;
      idxQ   <= bus.addr[IdxW+1:2];
      wdataQ <= bus.wdata;
    end
  end

  // Load data register; holds its value across stores, errors and idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdataQ <= 32'd0;
    end else if (access && !weQ) begin
      rdataQ <= mem[idxQ];
    end
  end

  // Array write; never reset, and reset forces IDLE so an aborted store is dropped.
  always_ff @(posedge clk) begin
    if (access && weQ) begin
      mem[idxQ] <= wdataQ;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three builds (LATENCY 2, 1, 15) share one stimulus stream,
// each checked every cycle against a transaction-timeline model, plus literal checks.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int NDut = 3;

  function automatic int latOf(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  always #5 clk = ~clk;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();
  dmem_responder_if bus2 ();

  assign bus0.req = req;  assign bus0.we = we;  assign bus0.addr = addr;  assign bus0.wdata = wdata;
  assign bus1.req = req;  assign bus1.we = we;  assign bus1.addr = addr;  assign bus1.wdata = wdata;
  assign bus2.req = req;  assign bus2.we = we;  assign bus2.addr = addr;  assign bus2.wdata = wdata;

  dmem_responder #(.DEPTH(256), .LATENCY(2))  dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_responder #(.DEPTH(256), .LATENCY(1))  dut1 (.clk(clk), .reset(reset), .bus(bus1));
  dmem_responder #(.DEPTH(256), .LATENCY(15)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic        ackV   [NDut];
  logic        errV   [NDut];
  logic        stallV [NDut];
  logic [31:0] rdataV [NDut];

  assign ackV[0] = bus0.ack;  assign errV[0] = bus0.err;  assign stallV[0] = bus0.stall;
  assign ackV[1] = bus1.ack;  assign errV[1] = bus1.err;  assign stallV[1] = bus1.stall;
  assign ackV[2] = bus2.ack;  assign errV[2] = bus2.err;  assign stallV[2] = bus2.stall;
  assign rdataV[0] = bus0.rdata;
  assign rdataV[1] = bus1.rdata;
  assign rdataV[2] = bus2.rdata;

  int nPass  = 0;
  int nTotal = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Model: each request is a timeline (accept cycle, ack cycle); effects land in the ack cycle.
  int          cyc = 0;
  int          accC  [NDut] = '{-1, -1, -1};
  int          ackC  [NDut] = '{-1, -1, -1};
  bit          pErr  [NDut];
  bit          pWe   [NDut];
  int          pIdx  [NDut];
  logic [31:0] pData [NDut];
  logic [31:0] rdM   [NDut] = '{32'd0, 32'd0, 32'd0};
  bit          rdK   [NDut] = '{1'b1, 1'b1, 1'b1};
  logic [31:0] memM  [NDut][256];
  bit          memK  [NDut][256];

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int k = 0; k < NDut; k++) begin
          accC[k] = -1;
          ackC[k] = -1;
          rdM[k]  = 32'd0;
          rdK[k]  = 1'b1;
        end
      end else begin
        cyc++;
        for (int k = 0; k < NDut; k++) begin
          // Previous cycle was IDLE if no transaction or it ended before that cycle.
          if ((ackC[k] < 0 || cyc - 1 > ackC[k]) && req) begin
            pErr[k]  = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
            pWe[k]   = we;
            pIdx[k]  = int'(addr[9:2]);
            pData[k] = wdata;
            accC[k]  = cyc - 1;
            ackC[k]  = pErr[k] ? cyc : cyc + latOf(k);
          end
          if (ackC[k] == cyc && !pErr[k]) begin
            if (pWe[k]) begin
              memM[k][pIdx[k]] = pData[k];
              memK[k][pIdx[k]] = 1'b1;
            end else begin
              rdM[k] = memM[k][pIdx[k]];
              rdK[k] = memK[k][pIdx[k]];
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of every build against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NDut; k++) begin
        logic ackE, errE, stallE;
        bit   inTxn;
        if (!reset) begin
          ackE = 1'b0; errE = 1'b0; stallE = 1'b0;
        end else begin
          inTxn  = (ackC[k] >= 0) && (cyc <= ackC[k]);
          ackE   = (ackC[k] >= 0) && (cyc == ackC[k]);
          errE   = ackE && pErr[k];
          stallE = (!inTxn && req) ||
                   (inTxn && !pErr[k] && cyc > accC[k] && cyc < ackC[k]);
        end
        check($sformatf("ack L%0d cyc %0d", latOf(k), cyc), 32'(ackV[k]), 32'(ackE));
        check($sformatf("err L%0d cyc %0d", latOf(k), cyc), 32'(errV[k]), 32'(errE));
        check($sformatf("stall L%0d cyc %0d", latOf(k), cyc), 32'(stallV[k]), 32'(stallE));
        if (rdK[k]) check($sformatf("rdata L%0d cyc %0d", latOf(k), cyc), rdataV[k], rdM[k]);
      end
    end
  end

  // Drive one request (from posedge+1) and measure ack cycle and stall cycles on build k.
  task automatic doReq(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit drop, input int chgAt, input logic [31:0] ca,
                       input logic [31:0] cd, output int ac, output int sc, output logic es);
    req = 1'b1; we = w; addr = a; wdata = d;
    ac = -1; sc = 0; es = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == chgAt) begin
        addr  = ca;
        wdata = cd;
      end
      @(negedge clk);
      if (stallV[k]) sc++;
      if (ackV[k]) begin
        ac = c;
        es = errV[k];
      end
      @(posedge clk); #1;
      if (ac >= 0) break;
    end
    if (drop) begin
      req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    end
  endtask

  task automatic simple(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int ac, output int sc, output logic es);
    doReq(k, w, a, d, 1'b1, -1, 32'd0, 32'd0, ac, sc, es);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  int   ac, sc, nAck;
  logic es;

  initial begin
    // Reset values
    @(negedge clk);
    check("reset rdata", bus0.rdata, 32'd0);
    check("reset ack", 32'(bus0.ack), 32'd0);
    check("reset stall", 32'(bus0.stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(3);

    // Store then load, LATENCY=2
    simple(0, 1'b1, 32'h10, 32'hDEADBEEF, ac, sc, es);
    check("store ack cycle", 32'(ac), 32'd3);
    check("store stall cycles", 32'(sc), 32'd3);
    idle(20);
    simple(0, 1'b0, 32'h10, 32'd0, ac, sc, es);
    check("load ack cycle", 32'(ac), 32'd3);
    check("load stall cycles", 32'(sc), 32'd3);
    check("load rdata", bus0.rdata, 32'hDEADBEEF);
    idle(20);

    // Misaligned and out-of-range errors
    simple(0, 1'b1, 32'h0, 32'h00000C0C, ac, sc, es);
    idle(20);
    simple(0, 1'b0, 32'h12, 32'd0, ac, sc, es);
    check("misaligned ack cycle", 32'(ac), 32'd1);
    check("misaligned err", {31'd0, es}, 32'd1);
    check("misaligned stall cycles", 32'(sc), 32'd1);
    check("rdata kept after err", bus0.rdata, 32'hDEADBEEF);
    idle(20);
    simple(0, 1'b1, 32'h400, 32'hFFFFFFFF, ac, sc, es);
    check("range ack cycle", 32'(ac), 32'd1);
    check("range err", {31'd0, es}, 32'd1);
    idle(20);
    simple(0, 1'b0, 32'h0, 32'd0, ac, sc, es);
    check("word0 err flag", {31'd0, es}, 32'd0);
    check("word0 unchanged", bus0.rdata, 32'h00000C0C);
    idle(20);

    // Reset mid-store
    simple(0, 1'b1, 32'h20, 32'hAAAAAAAA, ac, sc, es);
    idle(20);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    nAck = 0;
    @(negedge clk);
    if (bus0.ack) nAck++;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.ack) nAck++;
      @(posedge clk); #1;
    end
    check("aborted store acks", 32'(nAck), 32'd0);
    check("aborted store rdata", bus0.rdata, 32'd0);
    simple(0, 1'b0, 32'h20, 32'd0, ac, sc, es);
    check("word 0x20 preserved", bus0.rdata, 32'hAAAAAAAA);
    idle(20);

    // LATENCY=1 and LATENCY=15 builds
    simple(1, 1'b0, 32'h10, 32'd0, ac, sc, es);
    check("L1 ack cycle", 32'(ac), 32'd2);
    check("L1 stall cycles", 32'(sc), 32'd2);
    idle(20);
    simple(2, 1'b0, 32'h10, 32'd0, ac, sc, es);
    check("L15 ack cycle", 32'(ac), 32'd16);
    check("L15 stall cycles", 32'(sc), 32'd16);
    check("L15 rdata", bus2.rdata, 32'hDEADBEEF);
    idle(20);

    // Held request across ack: second ack LATENCY+2 after the first
    simple(0, 1'b1, 32'h8, 32'h08080808, ac, sc, es);
    idle(20);
    doReq(0, 1'b0, 32'h8, 32'd0, 1'b0, -1, 32'd0, 32'd0, ac, sc, es);
    check("held first ack", 32'(ac), 32'd3);
    doReq(0, 1'b0, 32'h8, 32'd0, 1'b1, -1, 32'd0, 32'd0, ac, sc, es);
    check("held second ack offset", 32'(ac + 1), 32'd4);
    check("held rdata", bus0.rdata, 32'h08080808);
    idle(20);

    // Input change while BUSY
    doReq(0, 1'b1, 32'h4, 32'h5555AAAA, 1'b1, 1, 32'h8, 32'd0, ac, sc, es);
    check("busy-change ack cycle", 32'(ac), 32'd3);
    idle(20);
    simple(0, 1'b0, 32'h4, 32'd0, ac, sc, es);
    check("word 0x4 latched data", bus0.rdata, 32'h5555AAAA);
    idle(20);
    simple(0, 1'b0, 32'h8, 32'd0, ac, sc, es);
    check("word 0x8 untouched", bus0.rdata, 32'h08080808);
    idle(20);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
